// File: rtl/bcd_serial_adder.sv
// rtl/bcd_serial_adder.sv - digit-serial packed-BCD adder, LSD first; optional BCD_SERIAL_INVALID_CHECK_EN
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  invalid
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic [IW-1:0]   idx_q, idx_d;

    logic [4:0]      raw;
    logic [3:0]      digit;
    logic            carry_next;
    logic            last_digit;
    logic            accept;

    assign accept     = (state_q == S_IDLE) && start;
    assign last_digit = (idx_q == IW'(DIGITS - 1));

    // Single-digit BCD slice: binary add, then +6 wrap when the sum leaves 0..9.
    // The low nibble of raw+6 equals raw[3:0]+6 mod 16, so the adjust stays 4 bits.
    always_comb begin
        raw        = 5'(a_q[3:0]) + 5'(b_q[3:0]) + 5'(carry_q);
        digit      = raw[3:0];
        carry_next = 1'b0;
        if (raw > 5'd9) begin
            digit      = raw[3:0] + 4'd6;
            carry_next = 1'b1;
        end
    end

    // Sequencer: latch operands on start, walk the digits, then pulse done.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    sum_d   = '0;
                    idx_d   = '0;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                // Operands shift so the slice always sees the current digit in [3:0].
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                carry_d = carry_next;
                for (int i = 0; i < DIGITS; i++) begin
                    if (idx_q == IW'(i)) begin
                        sum_d[i*4 +: 4] = digit;
                    end
                end
                idx_d = idx_q + IW'(1);
                if (last_digit) begin
                    cout_d  = carry_next;
                    idx_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
        end
    end

    assign busy = (state_q == S_ADD);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

`ifdef BCD_SERIAL_INVALID_CHECK_EN
    logic invalid_q, invalid_d;

    // Sticky flag: cleared on acceptance, set by any non-decimal operand digit.
    always_comb begin
        invalid_d = invalid_q;
        if (accept) begin
            invalid_d = 1'b0;
        end else if ((state_q == S_ADD) && ((a_q[3:0] > 4'd9) || (b_q[3:0] > 4'd9))) begin
            invalid_d = 1'b1;
        end
    end

    // Flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            invalid_q <= 1'b0;
        end else begin
            invalid_q <= invalid_d;
        end
    end

    assign invalid = invalid_q;
`else
    assign invalid = 1'b0;
`endif

endmodule
